// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with ALU-control decode, EX forwarding and load-use detect
// Optional macro ID_EX_FORWARD_EN enables EX/MEM and MEM/WB operand forwarding; undefined uses registered reads.
// Ports: clk, rst (async high), stall, flush, id_* decoded inputs, exmem_*/memwb_* forward sources,
//        alu_signal/alu_a/alu_b/store_data to the ALU, ex_* registered control, hazard_stall to ID/IF.
module id_ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic [REGBITS-1:0] id_rd,
  input  logic [WIDTH-1:0]   id_readA,
  input  logic [WIDTH-1:0]   id_readB,
  input  logic [WIDTH-1:0]   id_imm,
  input  logic [5:0]         id_funct,
  input  logic [1:0]         id_aluop,
  input  logic               id_alusrc,
  input  logic               id_regdst,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_memtoreg,
  input  logic               exmem_regwrite,
  input  logic [REGBITS-1:0] exmem_rd,
  input  logic [WIDTH-1:0]   exmem_data,
  input  logic               memwb_regwrite,
  input  logic [REGBITS-1:0] memwb_rd,
  input  logic [WIDTH-1:0]   memwb_data,
  output logic [2:0]         alu_signal,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [WIDTH-1:0]   store_data,
  output logic [REGBITS-1:0] ex_dest,
  output logic               ex_valid,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_memtoreg,
  output logic               ex_illegal,
  output logic               hazard_stall
);
  logic [2:0] dec_sig;
  logic dec_ok;
  logic alusrc_q;
  logic [REGBITS-1:0] rs_q, rt_q;
  logic [WIDTH-1:0] a_q, b_q, imm_q, fwd_a, fwd_b;
  always_comb begin
    dec_ok = id_aluop != 2'b10 || id_funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    dec_sig = id_aluop == 2'b01 ? 3'b110 :
              id_aluop == 2'b11 ? 3'b001 :
              id_aluop == 2'b00 ? 3'b010 :
              id_funct == 6'h22 ? 3'b110 :
              id_funct == 6'h24 ? 3'b000 :
              id_funct == 6'h25 ? 3'b001 :
              id_funct == 6'h2a ? 3'b111 : 3'b010;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      ex_valid <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_illegal <= 1'b0;
      alusrc_q <= 1'b0;
      alu_signal <= 3'b010;
      ex_dest <= '0;
      rs_q <= '0;
      rt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      imm_q <= '0;
    end else if (!stall) begin
      ex_valid <= id_valid;
      ex_regwrite <= id_valid && id_regwrite && dec_ok;
      ex_memread <= id_valid && id_memread;
      ex_memwrite <= id_valid && id_memwrite && dec_ok;
      ex_memtoreg <= id_valid && id_memtoreg;
      ex_illegal <= id_valid && !dec_ok;
      alusrc_q <= id_valid && id_alusrc;
      alu_signal <= dec_sig;
      ex_dest <= id_regdst ? id_rd : id_rt;
      rs_q <= id_rs;
      rt_q <= id_rt;
      a_q <= id_readA;
      b_q <= id_readB;
      imm_q <= id_imm;
    end
  end
`ifdef ID_EX_FORWARD_EN
  function automatic logic [WIDTH-1:0] fwd(input logic [REGBITS-1:0] r, input logic [WIDTH-1:0] v);
    return (exmem_regwrite && exmem_rd != '0 && exmem_rd == r) ? exmem_data :
           (memwb_regwrite && memwb_rd != '0 && memwb_rd == r) ? memwb_data : v;
  endfunction
  assign fwd_a = fwd(rs_q, a_q);
  assign fwd_b = fwd(rt_q, b_q);
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_data, memwb_regwrite, memwb_rd, memwb_data, rs_q, rt_q};
  assign fwd_a = a_q;
  assign fwd_b = b_q;
`endif
  assign alu_a = fwd_a;
  assign store_data = fwd_b;
  assign alu_b = alusrc_q ? imm_q : fwd_b;
  assign hazard_stall = ex_valid && ex_memread && ex_dest != '0 && (ex_dest == id_rs || ex_dest == id_rt);
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and randomised check of the ID/EX stage against an instruction-level model
module tb_id_ex_operand_stage;
  logic clk = 0, rst = 1, stall = 0, flush = 0, id_valid = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_rd = 0, exmem_rd = 0, memwb_rd = 0;
  logic [31:0] id_readA = 0, id_readB = 0, id_imm = 0, exmem_data = 0, memwb_data = 0;
  logic [5:0] id_funct = 0;
  logic [1:0] id_aluop = 0;
  logic id_alusrc = 0, id_regdst = 0, id_regwrite = 0, id_memread = 0, id_memwrite = 0, id_memtoreg = 0;
  logic exmem_regwrite = 0, memwb_regwrite = 0;
  logic [2:0] alu_signal;
  logic [31:0] alu_a, alu_b, store_data;
  logic [4:0] ex_dest;
  logic ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal, hazard_stall;
  int asserts = 0, fails = 0;
  always #5 clk = ~clk;
  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_readA(id_readA), .id_readB(id_readB),
    .id_imm(id_imm), .id_funct(id_funct), .id_aluop(id_aluop), .id_alusrc(id_alusrc),
    .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .alu_signal(alu_signal), .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data),
    .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_illegal(ex_illegal),
    .hazard_stall(hazard_stall)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  typedef struct {
    logic v, rw, mr, mw, mt, src, ill;
    logic [2:0] sig;
    logic [4:0] rs, rt, dest;
    logic [31:0] a, b, imm;
  } instr_t;
  instr_t m;
  logic [5:0] functs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  logic [2:0] ops [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
  function automatic instr_t bubble();
    instr_t x;
    x = '{default: '0};
    x.sig = 3'b010;
    return x;
  endfunction
  function automatic instr_t capture();
    instr_t x;
    logic known;
    x = bubble();
    known = 1'b1;
    case (id_aluop)
      2'b00: x.sig = 3'b010;
      2'b01: x.sig = 3'b110;
      2'b11: x.sig = 3'b001;
      default: begin
        known = 1'b0;
        for (int i = 0; i < 5; i++) if (functs[i] == id_funct) begin x.sig = ops[i]; known = 1'b1; end
      end
    endcase
    x.v = id_valid;
    x.ill = id_valid & ~known;
    x.rw = id_valid & id_regwrite & known;
    x.mw = id_valid & id_memwrite & known;
    x.mr = id_valid & id_memread;
    x.mt = id_valid & id_memtoreg;
    x.src = id_valid & id_alusrc;
    x.rs = id_rs;
    x.rt = id_rt;
    x.dest = id_regdst ? id_rd : id_rt;
    x.a = id_readA;
    x.b = id_readB;
    x.imm = id_imm;
    return x;
  endfunction
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
`ifdef ID_EX_FORWARD_EN
    if (r != 0 && exmem_regwrite && exmem_rd == r) return exmem_data;
    if (r != 0 && memwb_regwrite && memwb_rd == r) return memwb_data;
`endif
    return v;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst || flush) m <= bubble();
    else if (!stall) m <= capture();
  always @(negedge clk) begin
    chk("ex_valid", ex_valid, m.v);
    chk("ex_regwrite", ex_regwrite, m.rw);
    chk("ex_memread", ex_memread, m.mr);
    chk("ex_memwrite", ex_memwrite, m.mw);
    chk("ex_memtoreg", ex_memtoreg, m.mt);
    chk("ex_illegal", ex_illegal, m.ill);
    chk("alu_signal", alu_signal, m.sig);
    chk("ex_dest", ex_dest, m.dest);
    chk("alu_a", alu_a, fwd(m.rs, m.a));
    chk("store_data", store_data, fwd(m.rt, m.b));
    chk("alu_b", alu_b, m.src ? m.imm : fwd(m.rt, m.b));
    chk("hazard_stall", hazard_stall, m.v && m.mr && m.dest != 0 && (m.dest == id_rs || m.dest == id_rt));
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic ins(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] rs, rt, rd,
                     input logic [31:0] a, b, imm, input logic [5:0] ctl);
    id_valid = 1;
    id_aluop = op;
    id_funct = fn;
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
    id_readA = a;
    id_readB = b;
    id_imm = imm;
    {id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg} = ctl;
  endtask
  initial begin
    logic [31:0] e;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    chk("reset_valid", ex_valid, 0);
    chk("reset_signal", alu_signal, 3'b010);
    ins(2'b00, 0, 1, 2, 3, 10, 20, 0, 6'b011000);
    step();
    ins(2'b10, 6'h2a, 6, 7, 9, 5, 9, 0, 6'b011000);
    step();
    chk("slt_signal", alu_signal, 3'b111);
    chk("slt_a", alu_a, 5);
    chk("slt_b", alu_b, 9);
    chk("slt_dest", ex_dest, 9);
    ins(2'b00, 0, 8, 0, 10, 32'h99, 0, 0, 6'b011000);
    step();
    {exmem_regwrite, exmem_rd, exmem_data} = {1'b1, 5'd8, 32'h11};
    {memwb_regwrite, memwb_rd, memwb_data} = {1'b1, 5'd8, 32'h22};
`ifdef ID_EX_FORWARD_EN
    e = 32'h11;
`else
    e = 32'h99;
`endif
    #1 chk("fwd_exmem", alu_a, e);
    exmem_regwrite = 0;
`ifdef ID_EX_FORWARD_EN
    e = 32'h22;
`endif
    #1 chk("fwd_memwb", alu_a, e);
    exmem_regwrite = 1;
    exmem_rd = 0;
    memwb_rd = 0;
    #1 chk("fwd_r0", alu_a, 32'h99);
    {exmem_regwrite, memwb_regwrite} = 0;
    ins(2'b00, 0, 1, 4, 0, 0, 0, 8, 6'b101101);
    step();
    ins(2'b00, 0, 4, 5, 6, 1, 2, 0, 6'b011000);
    #1 chk("loaduse_hazard", hazard_stall, 1);
    stall = 1;
    flush = 1;
    step();
    chk("bubble_valid", ex_valid, 0);
    chk("bubble_memread", ex_memread, 0);
    chk("bubble_hazard", hazard_stall, 0);
    stall = 0;
    flush = 0;
    ins(2'b01, 0, 2, 3, 7, 100, 30, 0, 6'b011000);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      ins(2'b10, 6'h24, 5'(i + 9), 5'(i + 12), 5'(i + 20), 32'(i * 7), 32'(i * 3), 0, 6'b011000);
      step();
      chk("stall_signal", alu_signal, 3'b110);
      chk("stall_a", alu_a, 100);
      chk("stall_dest", ex_dest, 7);
    end
    flush = 1;
    step();
    chk("stallflush_valid", ex_valid, 0);
    stall = 0;
    flush = 0;
    ins(2'b10, 6'h3f, 1, 2, 3, 4, 5, 0, 6'b011010);
    step();
    chk("illegal_flag", ex_illegal, 1);
    chk("illegal_signal", alu_signal, 3'b010);
    chk("illegal_regwrite", ex_regwrite, 0);
    ins(2'b11, 0, 1, 2, 3, 4, 5, 32'hf0, 6'b101000);
    step();
    chk("ori_b", alu_b, 32'hf0);
    chk("ori_signal", alu_signal, 3'b001);
    for (int i = 0; i < 40; i++) begin
      ins(2'($urandom), $urandom_range(0, 1) ? functs[$urandom_range(0, 4)] : 6'($urandom),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom),
          $urandom, $urandom, $urandom, 6'($urandom));
      id_valid = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 5) == 0;
      {exmem_regwrite, exmem_rd, exmem_data} = {1'($urandom), 5'($urandom_range(0, 3)), 32'($urandom)};
      {memwb_regwrite, memwb_rd, memwb_data} = {1'($urandom), 5'($urandom_range(0, 3)), 32'($urandom)};
      step();
    end
    stall = 0;
    flush = 0;
    ins(2'b01, 0, 1, 2, 3, 4, 5, 0, 6'b011000);
    step();
    #1 rst = 1;
    #1 chk("midreset_valid", ex_valid, 0);
    chk("midreset_signal", alu_signal, 3'b010);
    chk("midreset_a", alu_a, 0);
    step();
    rst = 0;
    step();
    @(negedge clk);
    #1 $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
